// File: rtl/pool_controller.sv
// rtl/pool_controller.sv - 2x2 stride-2 pooling sequencer over an N x N feature buffer
// Max pooling by default; defining POOL_AVG_EN adds avg_sel for 2x2 averaging.
module pool_controller #(
  parameter int N  = 8,
  parameter int DW = 16,
  parameter int AW = 6,
  parameter int OW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
`ifdef POOL_AVG_EN
  input  logic          avg_sel,
`endif
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          wr_en,
  output logic [OW-1:0] wr_addr,
  output logic [DW-1:0] wr_data
);

  localparam int HALF = N / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
`ifdef POOL_AVG_EN
  localparam int ACCW = DW + 2;
`else
  localparam int ACCW = DW;
`endif

  typedef enum logic [2:0] {IDLE, R0, R1, R2, R3, LAST, WR, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          p, q, np, nq;
  logic signed [DW-1:0]   rd_s;
  logic signed [ACCW-1:0] acc, px, acc_next;
  logic [DW-1:0]          res;
  logic                   last_win;
`ifdef POOL_AVG_EN
  logic                   avg_mode;
`endif

  assign rd_s     = rd_data;
  assign px       = ACCW'(rd_s);
  assign last_win = (p == CW'(HALF - 1)) && (q == CW'(HALF - 1));

  function automatic logic [AW-1:0] addr_of(input int row, input int col);
    return AW'(row * N + col);
  endfunction

  // Next window in raster order, pcol fastest.
  always_comb begin
    nq = q + 1'b1;
    np = p;
    if (q == CW'(HALF - 1)) begin
      nq = '0;
      np = p + 1'b1;
    end
  end

  // Fold the pixel arriving this cycle into the running result.
  always_comb begin
    acc_next = (px > acc) ? px : acc;
    res      = acc_next[DW-1:0];
`ifdef POOL_AVG_EN
    if (avg_mode) begin
      acc_next = acc + px;
      res      = DW'(acc_next >>> 2);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      p       <= '0;
      q       <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
      rd_addr <= '0;
      wr_addr <= '0;
      wr_data <= '0;
`ifdef POOL_AVG_EN
      avg_mode <= 1'b0;
`endif
    end else begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state   <= R0;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= addr_of(0, 0);
`ifdef POOL_AVG_EN
            avg_mode <= avg_sel;
`endif
          end
        end
        R0: begin
          state   <= R1;
          rd_en   <= 1'b1;
          rd_addr <= addr_of(2 * int'(p), 2 * int'(q) + 1);
        end
        R1: begin
          // rd_data now carries the R0 pixel.
          acc     <= px;
          state   <= R2;
          rd_en   <= 1'b1;
          rd_addr <= addr_of(2 * int'(p) + 1, 2 * int'(q));
        end
        R2: begin
          acc     <= acc_next;
          state   <= R3;
          rd_en   <= 1'b1;
          rd_addr <= addr_of(2 * int'(p) + 1, 2 * int'(q) + 1);
        end
        R3: begin
          acc   <= acc_next;
          state <= LAST;
        end
        LAST: begin
          acc     <= acc_next;
          state   <= WR;
          wr_en   <= 1'b1;
          wr_data <= res;
          wr_addr <= OW'(int'(p) * HALF + int'(q));
        end
        WR: begin
          if (last_win) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            p       <= np;
            q       <= nq;
            state   <= R0;
            rd_en   <= 1'b1;
            rd_addr <= addr_of(2 * int'(np), 2 * int'(nq));
          end
        end
        DONE: begin
          p     <= '0;
          q     <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool_controller.sv
// tb/tb_pool_controller.sv - directed bench for pool_controller (N=4 and N=2 instances)
module tb_pool_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        rst4, go4, avg_sel4;
  logic        busy4, done4, rd_en4, wr_en4;
  logic [3:0]  rd_addr4;
  logic [15:0] rd_data4;
  logic [1:0]  wr_addr4;
  logic [15:0] wr_data4;
  logic [15:0] mem4 [16];

  logic        rst2, go2, avg_sel2;
  logic        busy2, done2, rd_en2, wr_en2;
  logic [1:0]  rd_addr2;
  logic [15:0] rd_data2;
  logic [0:0]  wr_addr2;
  logic [15:0] wr_data2;
  logic [15:0] mem2 [4];

  pool_controller #(.N(4), .DW(16), .AW(4), .OW(2)) dut4 (
    .clk(clk), .rst(rst4), .go(go4),
`ifdef POOL_AVG_EN
    .avg_sel(avg_sel4),
`endif
    .busy(busy4), .done(done4), .rd_en(rd_en4), .rd_addr(rd_addr4),
    .rd_data(rd_data4), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4)
  );

  pool_controller #(.N(2), .DW(16), .AW(2), .OW(1)) dut2 (
    .clk(clk), .rst(rst2), .go(go2),
`ifdef POOL_AVG_EN
    .avg_sel(avg_sel2),
`endif
    .busy(busy2), .done(done2), .rd_en(rd_en2), .rd_addr(rd_addr2),
    .rd_data(rd_data2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2)
  );

  // Feature buffers: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en4) rd_data4 <= mem4[rd_addr4];
    if (rd_en2) rd_data2 <= mem2[rd_addr2];
  end

  int wa4[$];
  logic [15:0] wd4[$];
  int ra4[$];
  int dones4 = 0, overlap4 = 0;
  int wa2[$];
  logic [15:0] wd2[$];
  int dones2 = 0, overlap2 = 0;

  always @(negedge clk) begin
    if (wr_en4) begin wa4.push_back(int'(wr_addr4)); wd4.push_back(wr_data4); end
    if (rd_en4) ra4.push_back(int'(rd_addr4));
    if (done4) dones4++;
    if (rd_en4 && wr_en4) overlap4++;
    if (wr_en2) begin wa2.push_back(int'(wr_addr2)); wd2.push_back(wr_data2); end
    if (done2) dones2++;
    if (rd_en2 && wr_en2) overlap2++;
  end

  // One full N=4 pass from a go pulse; glitch>0 re-pulses go at that cycle.
  task automatic run_check4(input string tag, input int glitch, input logic [15:0] e[4]);
    int w0, r0, d0, o0, cyc, b;
    w0 = wa4.size(); r0 = ra4.size(); d0 = dones4; o0 = overlap4;
    @(posedge clk); #1 go4 = 1'b1;
    @(posedge clk); cyc = 1; #1 go4 = 1'b0;
    while (cyc < 200) begin
      @(negedge clk);
      if (done4) break;
      @(posedge clk); cyc++;
      #1 if (glitch > 0) go4 = (cyc == glitch);
    end
    go4 = 1'b0;
    vectors++;
    if (cyc !== 25) begin
      miscompares++; $display("FAIL %s done_latency: got %0d expected 25", tag, cyc);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (wa4.size() - w0 !== 4) begin
      miscompares++; $display("FAIL %s write_count: got %0d expected 4", tag, wa4.size() - w0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (wa4[w0+i] !== i || wd4[w0+i] !== e[i]) begin
          miscompares++;
          $display("FAIL %s write%0d: got addr %0d data %0d expected addr %0d data %0d",
                   tag, i, wa4[w0+i], $signed(wd4[w0+i]), i, $signed(e[i]));
        end
      end
    end
    vectors++;
    if (ra4.size() - r0 !== 16) begin
      miscompares++; $display("FAIL %s read_count: got %0d expected 16", tag, ra4.size() - r0);
    end else begin
      for (int w = 0; w < 4; w++) begin
        b = (w / 2) * 8 + (w % 2) * 2;
        vectors++;
        if (ra4[r0+4*w] !== b || ra4[r0+4*w+1] !== b + 1 ||
            ra4[r0+4*w+2] !== b + 4 || ra4[r0+4*w+3] !== b + 5) begin
          miscompares++;
          $display("FAIL %s rd_addr_window%0d: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                   tag, w, ra4[r0+4*w], ra4[r0+4*w+1], ra4[r0+4*w+2], ra4[r0+4*w+3],
                   b, b + 1, b + 4, b + 5);
        end
      end
    end
    vectors++;
    if (dones4 - d0 !== 1) begin
      miscompares++; $display("FAIL %s done_count: got %0d expected 1", tag, dones4 - d0);
    end
    vectors++;
    if (overlap4 - o0 !== 0) begin
      miscompares++; $display("FAIL %s rd_wr_overlap: got %0d expected 0", tag, overlap4 - o0);
    end
    vectors++;
    if (busy4 !== 1'b0) begin
      miscompares++; $display("FAIL %s idle_after: busy %0b expected 0", tag, busy4);
    end
  endtask

  task automatic test_reset();
    rst4 = 1'b0; go4 = 1'b0; avg_sel4 = 1'b0;
    rst2 = 1'b0; go2 = 1'b0; avg_sel2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy4, done4, rd_en4, wr_en4} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_strobes: got %b expected 0000", {busy4, done4, rd_en4, wr_en4});
    end
    vectors++;
    if (rd_addr4 !== 4'd0 || wr_addr4 !== 2'd0 || wr_data4 !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_data: got rd_addr %0d wr_addr %0d wr_data %0d expected 0 0 0",
               rd_addr4, wr_addr4, wr_data4);
    end
    rst4 = 1'b1; rst2 = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy4 !== 1'b0 || rd_en4 !== 1'b0) begin
      miscompares++; $display("FAIL wait_idle: busy %0b rd_en %0b expected 0 0", busy4, rd_en4);
    end
  endtask

  task automatic test_ramp();
    logic [15:0] e[4];
    for (int i = 0; i < 16; i++) mem4[i] = 16'(i);
    e = '{16'd5, 16'd7, 16'd13, 16'd15};
    run_check4("ramp", 0, e);
  endtask

  task automatic test_signed();
    logic [15:0] e[4];
    mem4 = '{-16'sd5, -16'sd2, 16'sd100, -16'sd32768,
             -16'sd8, -16'sd3, -16'sd1, 16'sd32767,
              16'sd7,  16'sd7, -16'sd9, -16'sd9,
              16'sd7,  16'sd6, -16'sd10, -16'sd9};
    e = '{-16'sd2, 16'sd32767, 16'sd7, -16'sd9};
    run_check4("signed", 0, e);
  endtask

  task automatic test_go_while_busy();
    logic [15:0] e[4];
    for (int i = 0; i < 16; i++) mem4[i] = 16'(i);
    e = '{16'd5, 16'd7, 16'd13, 16'd15};
    run_check4("go_busy", 10, e);
  endtask

  task automatic test_go_held();
    int cyc, w0;
    @(posedge clk); #1 go4 = 1'b1;
    cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      if (done4) break;
      cyc++;
    end
    vectors++;
    if (cyc >= 60) begin miscompares++; $display("FAIL go_held_done: timeout after %0d cycles", cyc); end
    @(negedge clk);
    vectors++;
    if (busy4 !== 1'b0) begin
      miscompares++; $display("FAIL go_held_idle: busy %0b expected 0", busy4);
    end
    @(negedge clk);
    vectors++;
    if (busy4 !== 1'b1 || rd_en4 !== 1'b1 || rd_addr4 !== 4'd0) begin
      miscompares++;
      $display("FAIL go_held_restart: busy %0b rd_en %0b rd_addr %0d expected 1 1 0", busy4, rd_en4, rd_addr4);
    end
    go4 = 1'b0;
    w0 = wa4.size();
    cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      if (done4) break;
      cyc++;
    end
    vectors++;
    if (wa4.size() - w0 !== 4) begin
      miscompares++; $display("FAIL go_held_writes: got %0d expected 4", wa4.size() - w0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    logic [15:0] e[4];
    for (int i = 0; i < 16; i++) mem4[i] = 16'(i);
    @(posedge clk); #1 go4 = 1'b1;
    @(posedge clk); #1 go4 = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (rd_en4 !== 1'b1 || rd_addr4 !== 4'd6) begin
      miscompares++; $display("FAIL mid_r2: rd_en %0b rd_addr %0d expected 1 6", rd_en4, rd_addr4);
    end
    w0 = wa4.size(); d0 = dones4;
    rst4 = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy4, done4, rd_en4, wr_en4} !== 4'b0000 || rd_addr4 !== 4'd0 ||
        wr_addr4 !== 2'd0 || wr_data4 !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: strobes %b rd_addr %0d wr_addr %0d wr_data %0d expected all 0",
               {busy4, done4, rd_en4, wr_en4}, rd_addr4, wr_addr4, wr_data4);
    end
    rst4 = 1'b1;
    repeat (40) @(negedge clk);
    vectors++;
    if (wa4.size() !== w0 || dones4 !== d0 || busy4 !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_quiet: writes %0d done %0d busy %0b expected 0 0 0",
               wa4.size() - w0, dones4 - d0, busy4);
    end
    e = '{16'd5, 16'd7, 16'd13, 16'd15};
    run_check4("after_reset", 0, e);
  endtask

  task automatic test_n2();
    int cyc, w0, d0;
    mem2 = '{-16'sd3, -16'sd7, -16'sd1, -16'sd9};
    w0 = wa2.size(); d0 = dones2;
    @(posedge clk); #1 go2 = 1'b1;
    @(posedge clk); cyc = 1; #1 go2 = 1'b0;
    while (cyc < 100) begin
      @(negedge clk);
      if (done2) break;
      @(posedge clk); cyc++;
    end
    vectors++;
    if (cyc !== 7) begin miscompares++; $display("FAIL n2_latency: got %0d expected 7", cyc); end
    repeat (10) @(negedge clk);
    vectors++;
    if (wa2.size() - w0 !== 1) begin
      miscompares++; $display("FAIL n2_write_count: got %0d expected 1", wa2.size() - w0);
    end else begin
      vectors++;
      if (wa2[w0] !== 0 || wd2[w0] !== 16'hFFFF) begin
        miscompares++;
        $display("FAIL n2_write: got addr %0d data %0d expected addr 0 data -1", wa2[w0], $signed(wd2[w0]));
      end
    end
    vectors++;
    if (dones2 - d0 !== 1 || overlap2 !== 0) begin
      miscompares++; $display("FAIL n2_done_overlap: done %0d overlap %0d expected 1 0", dones2 - d0, overlap2);
    end
  endtask

`ifdef POOL_AVG_EN
  task automatic test_avg();
    logic [15:0] e[4];
    for (int i = 0; i < 16; i++) mem4[i] = 16'd0;
    mem4[0] = 16'sd1;  mem4[1] = 16'sd2;  mem4[4] = 16'sd3;  mem4[5] = 16'sd5;
    mem4[2] = -16'sd1; mem4[3] = -16'sd2; mem4[6] = -16'sd3; mem4[7] = -16'sd5;
    e = '{16'sd2, -16'sd3, 16'sd0, 16'sd0};
    avg_sel4 = 1'b1;
    run_check4("avg", 0, e);
    avg_sel4 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_ramp();
    test_signed();
    test_go_while_busy();
    test_go_held();
    test_reset_mid();
    test_n2();
`ifdef POOL_AVG_EN
    test_avg();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pool_controller.md
POOL_CONTROLLER -- requirements
Module: pool_controller

Interface
REQ-001 Parameter N, default 8: feature-map width and height in pixels; SHALL be even and at least 2.
REQ-002 Parameter DW, default 16: pixel width; pixels are signed two's complement.
REQ-003 Parameter AW, default 6: read-address width; SHALL satisfy 2^AW >= N*N.
REQ-004 Parameter OW, default 4: write-address width; SHALL satisfy 2^OW >= (N/2)*(N/2).
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 go  input  1  start request; sampled only in IDLE.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 rd_en  output  1  feature-buffer read strobe.
REQ-011 rd_addr  output  AW  read address = row*N + col.
REQ-012 rd_data  input  DW  read data, valid exactly 1 cycle after rd_en.
REQ-013 wr_en  output  1  pooled-result write strobe.
REQ-014 wr_addr  output  OW  write address = prow*(N/2) + pcol.
REQ-015 wr_data  output  DW  pooled result.

Function
REQ-016 Performs 2x2, stride-2 pooling over the N x N buffer; windows are processed in raster order, pcol fastest.
REQ-017 FSM states: IDLE, R0, R1, R2, R3, LAST, WR, DONE.
REQ-018 IDLE: go=1 -> R0 on the next edge; otherwise stay in IDLE.
REQ-019 R0..R3 SHALL each assert rd_en for one cycle, with addresses (2p,2q), (2p,2q+1), (2p+1,2q), (2p+1,2q+1) respectively; R0->R1->R2->R3->LAST unconditionally.
REQ-020 Accumulator: in R1, load acc with rd_data; in R2, R3 and LAST, set acc = max(acc, rd_data) using signed compare.
REQ-021 WR: wr_en=1 for one cycle, wr_data=acc, wr_addr = current window index.
REQ-022 WR -> DONE if the window is the last one (p=q=N/2-1); otherwise advance q (wrap to 0 and increment p) and go to R0.
REQ-023 DONE: done=1 for one cycle, clear counters, then go to IDLE.
REQ-024 Each window takes 6 cycles; total from go sampled to done = 6*(N/2)^2 + 1 cycles.
REQ-025 rd_en and wr_en SHALL never be high in the same cycle.
REQ-026 go while busy=1 SHALL be ignored, with no effect on counters or state.
REQ-027 go held high through DONE starts a new pass only after one cycle in IDLE.
REQ-028 N=2 SHALL perform exactly one window, then DONE.
REQ-029 Outputs rd_en, wr_en and done SHALL be zero in IDLE; rd_addr, wr_addr and wr_data hold their last values when their strobes are low.

Reset
REQ-030 rst=0 on an edge: state=IDLE; p, q and acc = 0; busy, done, rd_en and wr_en = 0; rd_addr, wr_addr and wr_data = 0.
REQ-031 Reset mid-operation SHALL abort with no further writes, and SHALL NOT issue done.
REQ-032 After rst is released, the block SHALL wait in IDLE for go.

Configuration
REQ-033 Macro POOL_AVG_EN, when defined, SHALL add input avg_sel (1 bit, sampled with go).
REQ-034 With POOL_AVG_EN and avg_sel=1: acc is a DW+2-bit signed sum; wr_data = sum arithmetically shifted right by 2 (truncating toward minus infinity). With avg_sel=0, behaviour is max pooling.
REQ-035 Without POOL_AVG_EN: there is no avg_sel port, max pooling only, and acc is DW bits.

Verification
REQ-036 N=4, buffer = 0..15, go pulse -> writes 5, 7, 13, 15 at wr_addr 0..3; done 25 cycles after go is sampled.
REQ-037 N=2, pixels {-3, -7, -1, -9} -> a single write of -1 at addr 0; done at cycle 7.
REQ-038 N=4, rst=0 asserted in the R2 of window 1 -> no further wr_en, no done, all outputs 0; a new go yields a full correct pass.
REQ-039 go pulsed at cycle 10 of an N=4 pass -> ignored; exactly 4 writes and one done.
REQ-040 POOL_AVG_EN, avg_sel=1, window {1, 2, 3, 5} -> wr_data 2; window {-1, -2, -3, -5} -> wr_data -3.
REQ-041 All runs: rd_en and wr_en are never high together; rd_addr sequence is 0, 1, 4, 5, 2, 3, 6, 7, ... for N=4.
